// File: rtl/branch_flush_ctrl_pkg.sv
// Shared types for the redirect path: provider record, FSM states and wrap-safe age compare.
package branch_flush_ctrl_pkg;

    localparam int NUM_PROV   = 4;
    localparam int SQN_W      = 6;
    localparam int PC_W       = 32;
    localparam int NUM_STAGES = 4;

    typedef logic [SQN_W-1:0] sqn_t;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] dstPC;
        sqn_t            sqN;
        sqn_t            loadSqN;
        sqn_t            storeSqN;
        logic            flush;
    } BranchProv;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DRAIN      = 2'd1,
        DRAIN_LAST = 2'd2
    } state_t;

    // Sequence numbers wrap, so age is the sign of the modular difference.
    function automatic logic is_older(sqn_t a, sqn_t b);
        sqn_t diff;
        diff = a - b;
        return diff[SQN_W-1];
    endfunction

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// Provider inputs, backend status and the broadcast branch bus of the flush controller.
interface branch_flush_ctrl_if;
    import branch_flush_ctrl_pkg::*;

    logic                       IN_en;
    logic                       IN_stall;
    logic [NUM_PROV-1:0]        IN_provTaken;
    logic [NUM_PROV*SQN_W-1:0]  IN_provSqN;
    logic [NUM_PROV*SQN_W-1:0]  IN_provLoadSqN;
    logic [NUM_PROV*SQN_W-1:0]  IN_provStoreSqN;
    logic [NUM_PROV*PC_W-1:0]   IN_provDstPC;
    logic [NUM_PROV-1:0]        IN_provFlush;
    logic [SQN_W-1:0]           IN_robCurSqN;
    logic [SQN_W-1:0]           IN_rnNextSqN;

    logic                       OUT_branchTaken;
    logic [SQN_W-1:0]           OUT_branchSqN;
    logic [SQN_W-1:0]           OUT_branchLoadSqN;
    logic [SQN_W-1:0]           OUT_branchStoreSqN;
    logic [PC_W-1:0]            OUT_branchDstPC;
    logic                       OUT_branchFlush;
    logic [NUM_STAGES-1:0]      OUT_stageValid;
    logic                       OUT_frontendEn;
    logic                       OUT_mispredFlush;
    logic [SQN_W-1:0]           OUT_flushSqN;

    modport master (
        output IN_en, IN_stall, IN_provTaken, IN_provSqN, IN_provLoadSqN,
               IN_provStoreSqN, IN_provDstPC, IN_provFlush, IN_robCurSqN, IN_rnNextSqN,
        input  OUT_branchTaken, OUT_branchSqN, OUT_branchLoadSqN, OUT_branchStoreSqN,
               OUT_branchDstPC, OUT_branchFlush, OUT_stageValid, OUT_frontendEn,
               OUT_mispredFlush, OUT_flushSqN
    );

    modport slave (
        input  IN_en, IN_stall, IN_provTaken, IN_provSqN, IN_provLoadSqN,
               IN_provStoreSqN, IN_provDstPC, IN_provFlush, IN_robCurSqN, IN_rnNextSqN,
        output OUT_branchTaken, OUT_branchSqN, OUT_branchLoadSqN, OUT_branchStoreSqN,
               OUT_branchDstPC, OUT_branchFlush, OUT_stageValid, OUT_frontendEn,
               OUT_mispredFlush, OUT_flushSqN
    );

endinterface

// File: rtl/branch_flush_ctrl_branch_select.sv
// Combinational oldest-redirect picker; zero latency, lowest index wins ties.
module branch_select
    import branch_flush_ctrl_pkg::*;
(
    input  BranchProv prov_i [NUM_PROV],
    input  logic      mispred_flush_i,
    input  sqn_t      flush_sqn_i,
    output BranchProv sel_o
);

    logic qual;

    always_comb begin
        sel_o = '0;
        qual  = 1'b0;
        for (int i = 0; i < NUM_PROV; i++) begin
            // While draining only redirects older than the one being drained matter.
            qual = prov_i[i].taken && (!mispred_flush_i || is_older(prov_i[i].sqN, flush_sqn_i));
            if (qual && (!sel_o.taken || is_older(prov_i[i].sqN, sel_o.sqN))) begin
                sel_o = prov_i[i];
            end
        end
    end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Redirect arbiter plus frontend stage-valid shifter and mispredict drain FSM.
// Branch bus is combinational; stage valids and drain state update one cycle later.
module branch_flush_ctrl
    import branch_flush_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    branch_flush_ctrl_if.slave bus
);

    BranchProv             prov [NUM_PROV];
    BranchProv             sel;
    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] stage_valid_q, stage_valid_d;
    sqn_t                  flush_sqn_q, flush_sqn_d;
    logic                  mispred_flush;
    logic                  frontend_en;
    logic                  rob_caught_up;

    always_comb begin
        for (int i = 0; i < NUM_PROV; i++) begin
            prov[i].taken    = bus.IN_provTaken[i];
            prov[i].dstPC    = bus.IN_provDstPC[i*PC_W +: PC_W];
            prov[i].sqN      = bus.IN_provSqN[i*SQN_W +: SQN_W];
            prov[i].loadSqN  = bus.IN_provLoadSqN[i*SQN_W +: SQN_W];
            prov[i].storeSqN = bus.IN_provStoreSqN[i*SQN_W +: SQN_W];
            prov[i].flush    = bus.IN_provFlush[i];
        end
    end

    branch_select u_select (
        .prov_i          (prov),
        .mispred_flush_i (mispred_flush),
        .flush_sqn_i     (flush_sqn_q),
        .sel_o           (sel)
    );

    assign mispred_flush = (state_q != RUN);
    assign frontend_en   = bus.IN_en & ~bus.IN_stall & ~sel.taken;
    assign rob_caught_up = (bus.IN_robCurSqN == bus.IN_rnNextSqN);

    always_comb begin
        state_d       = state_q;
        stage_valid_d = stage_valid_q;
        flush_sqn_d   = flush_sqn_q;
        if (sel.taken) begin
            stage_valid_d = '0;
            flush_sqn_d   = sel.sqN;
            state_d       = rob_caught_up ? RUN : DRAIN;
        end else begin
            case (state_q)
                RUN: begin
                    if (frontend_en) begin
                        stage_valid_d = {stage_valid_q[NUM_STAGES-2:0], 1'b1};
                    end
                end
                DRAIN: begin
                    stage_valid_d = '0;
                    if (rob_caught_up) begin
                        state_d = DRAIN_LAST;
                    end
                end
                DRAIN_LAST: begin
                    // One extra empty cycle so the last commit settles in rename.
                    stage_valid_d = '0;
                    state_d       = RUN;
                end
                default: begin
                    stage_valid_d = '0;
                    state_d       = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            stage_valid_q <= '0;
            flush_sqn_q   <= '0;
        end else begin
            state_q       <= state_d;
            stage_valid_q <= stage_valid_d;
            flush_sqn_q   <= flush_sqn_d;
        end
    end

    assign bus.OUT_branchTaken    = sel.taken;
    assign bus.OUT_branchSqN      = sel.sqN;
    assign bus.OUT_branchLoadSqN  = sel.loadSqN;
    assign bus.OUT_branchStoreSqN = sel.storeSqN;
    assign bus.OUT_branchDstPC    = sel.dstPC;
    assign bus.OUT_branchFlush    = sel.flush;
    assign bus.OUT_stageValid     = stage_valid_q;
    assign bus.OUT_frontendEn     = frontend_en;
    assign bus.OUT_mispredFlush   = mispred_flush;
    assign bus.OUT_flushSqN       = flush_sqn_q;

endmodule

// File: doc/branch_flush_ctrl.md
Name: branch_flush_ctrl

Overview:
Central redirect arbiter and frontend sequencer. Each cycle it picks the oldest taken redirect from NUM_PROV branch providers (ALUs, load buffer, ROB/IRQ) and broadcasts it as the single core-wide branch bus. It also owns the IF->DE->RN->RV stage-valid shift register and the mispredict drain FSM. After a redirect, the FSM holds the frontend empty until the ROB has retired everything up to rename.

Parameters:
NUM_PROV, 4, number of redirect providers
SQN_W, 6, width of sqN/loadSqN/storeSqN (wrap-around sequence numbers)
PC_W, 32, redirect target width
NUM_STAGES, 4, frontend stage-valid bits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
IN_en  in  1  global core enable
IN_stall  in  1  backend resources full (RV/LB/SQ/ROB credit check computed outside)
IN_provTaken  in  NUM_PROV  provider i requests redirect
IN_provSqN  in  NUM_PROV*SQN_W  sqN of redirecting op, slice i
IN_provLoadSqN  in  NUM_PROV*SQN_W  load sqN to restore, slice i
IN_provStoreSqN  in  NUM_PROV*SQN_W  store sqN to restore, slice i
IN_provDstPC  in  NUM_PROV*PC_W  redirect target, slice i
IN_provFlush  in  NUM_PROV  provider requests full flush
IN_robCurSqN  in  SQN_W  next sqN to commit
IN_rnNextSqN  in  SQN_W  next sqN rename will allocate
OUT_branchTaken  out  1  redirect this cycle
OUT_branchSqN, OUT_branchLoadSqN, OUT_branchStoreSqN  out  SQN_W each  fields of the selected provider
OUT_branchDstPC  out  PC_W  field of the selected provider
OUT_branchFlush  out  1  field of the selected provider
OUT_stageValid  out  NUM_STAGES  per-stage valid, bit0 = IF
OUT_frontendEn  out  1  frontend may advance
OUT_mispredFlush  out  1  drain in progress
OUT_flushSqN  out  SQN_W  sqN of the redirect being drained

Behaviour:
- Age compare: A older than B iff $signed(A-B) < 0, computed at SQN_W bits so wrap-around is handled.
- Selection (combinational, zero latency): scan i=0..NUM_PROV-1.
  - Candidate i qualifies if provTaken[i], and either !mispredFlush or provSqN[i] is older than flushSqN.
  - Winner is the oldest qualifying candidate; on equal sqN the lowest index wins.
  - No qualifying candidate -> branchTaken=0 and all branch fields 0.
- OUT_frontendEn = IN_en & !IN_stall & !OUT_branchTaken (combinational).
- FSM states: RUN, DRAIN, DRAIN_LAST. Registered; branch input has priority over every state.
  - Any state, branchTaken:
    - stageValid <= 0 and flushSqN <= branchSqN.
    - Next state is DRAIN if robCurSqN != rnNextSqN, else RUN.
  - RUN, no branch:
    - frontendEn -> stageValid <= {stageValid[NUM_STAGES-2:0],1}.
    - Otherwise stageValid holds.
  - DRAIN:
    - stageValid <= 0.
    - robCurSqN == rnNextSqN -> DRAIN_LAST; otherwise stay.
  - DRAIN_LAST: stageValid <= 0, next state RUN. The extra cycle lets the final commit settle in rename.
- OUT_mispredFlush = (state != RUN).
- Reset values (async): state RUN, stageValid 0, flushSqN 0, mispredFlush 0.
  - Combinational outputs follow from inputs; reset during DRAIN returns to RUN immediately.
- Boundaries:
  - A younger redirect arriving during DRAIN is ignored.
  - An older one restarts DRAIN with the new flushSqN.
  - Simultaneous branch and IN_stall: the branch wins and stageValid clears.
  - IN_en=0 in RUN freezes stageValid.

Decomposition:
- Shared package holds the BranchProv struct (taken, dstPC, sqN, loadSqN, storeSqN, flush), the SQN_W constant and an age-compare function.
- One sub-module, branch_select: the combinational oldest-provider picker, reusable in the LSU.
- The FSM and shift register stay in the top module.

Test Plan:
- Cold start: release rst, IN_en=1, IN_stall=0 -> stageValid 0001, 0011, 0111, 1111 on successive cycles; frontendEn=1.
- Oldest wins: taken[0] sqN=10, taken[2] sqN=7, same cycle -> branchSqN=7 with provider-2 dstPC; equal sqN=7 on providers 1 and 3 -> provider 1.
- Wrap-around: provider sqN=62 vs sqN=1 (SQN_W=6) -> 62 selected as older.
- Drain sequence: branch sqN=20 with robCur=15, rnNext=22 -> mispredFlush=1, flushSqN=20, stageValid held 0. When robCur reaches 22 -> one DRAIN_LAST cycle, then RUN and refill begins.
- Redirect during drain: in DRAIN with flushSqN=20, provider sqN=25 -> ignored (branchTaken=0); provider sqN=18 -> taken, flushSqN=18.
- Async reset mid-DRAIN: assert rst between clock edges -> mispredFlush and stageValid go 0 immediately, state RUN.
